// File: rtl/byte_fifo_v.sv
// ---------------------------------------------------------------------------
// byte_fifo_v
//   Synchronous byte FIFO sitting behind simple_connect_v. It decouples the
//   producer from a slower consumer with a write-enable/read-enable interface
//   and registered read data (1-cycle latency, no fall-through).
//
// Parameters
//   WIDTH  data width in bits (8, matches the simple_connect_v data path)
//   DEPTH  number of entries; must be a power of 2 and >= 2
//   AW     pointer address width, derived as $clog2(DEPTH)
//
// Ports
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   d_in    in   write data (from simple_connect_v d_out)
//   wr_en   in   write request
//   full    out  FIFO holds DEPTH entries
//   rd_en   in   read request
//   d_out   out  registered read data, holds until the next accepted read
//   empty   out  FIFO holds 0 entries
//   count   out  occupancy 0..DEPTH
//
// Optional feature, macro BYTE_FIFO_ERR_EN (undefined by default):
//   ovf     out  sticky: a write request was dropped
//   udf     out  sticky: a read request hit an empty FIFO
//   err_clr in   synchronous clear of ovf/udf; a same-cycle set wins
// ---------------------------------------------------------------------------
module byte_fifo_v #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_in,
    input  logic             wr_en,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] d_out,
    output logic             empty,
    output logic [AW:0]      count
`ifdef BYTE_FIFO_ERR_EN
    ,
    output logic             ovf,
    output logic             udf,
    input  logic             err_clr
`endif
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the address bits coincide.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] d_out_q,  d_out_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic rd_acc;
    logic wr_acc;

    // Status comes only from registered pointers, never from wr_en/rd_en.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign d_out = d_out_q;

    assign rd_acc = rd_en & ~empty;
    // A read on the same edge frees a slot, so a full FIFO still takes a write.
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        d_out_d  = d_out_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            d_out_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            d_out_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            d_out_q  <= d_out_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= d_in;
    end

`ifdef BYTE_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // Set conditions are applied last so they override a clear.
        if (wr_en & ~wr_acc) ovf_d = 1'b1;
        if (rd_en & empty)   udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_byte_fifo_v.sv
// ---------------------------------------------------------------------------
// tb_byte_fifo_v
//   Directed + randomized bench for byte_fifo_v. The reference is a queue of
//   bytes with a capacity of DEPTH: a read pops the head into the expected
//   d_out, a write pushes to the tail if room exists (counting the slot a
//   same-edge read frees). Status is checked against the queue size.
// ---------------------------------------------------------------------------
module tb_byte_fifo_v;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             resetn;
    logic [WIDTH-1:0] d_in;
    logic             wr_en;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] d_out;
    logic             empty;
    logic [AW:0]      count;
`ifdef BYTE_FIFO_ERR_EN
    logic             ovf;
    logic             udf;
    logic             err_clr;
`endif

    byte_fifo_v #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (d_in),
        .wr_en  (wr_en),
        .full   (full),
        .rd_en  (rd_en),
        .d_out  (d_out),
        .empty  (empty),
        .count  (count)
`ifdef BYTE_FIFO_ERR_EN
        ,
        .ovf    (ovf),
        .udf    (udf),
        .err_clr(err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] dout_m;
    logic [7:0] popped[$];
`ifdef BYTE_FIFO_ERR_EN
    logic ovf_m, udf_m;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".d_out"}, 32'(d_out), 32'(dout_m));
`ifdef BYTE_FIFO_ERR_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(ovf_m));
        chk({tag, ".udf"}, 32'(udf), 32'(udf_m));
`endif
    endtask

    // One clock of stimulus: drive on the falling edge, update the model at
    // the rising edge, check 1 time unit later, then return to idle.
    task automatic step(input string tag, input logic wr, input logic rd,
                        input logic [7:0] din, output logic wok);
        logic rok;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        d_in  = din;
        @(posedge clk);
        rok = rd && (q.size() > 0);
        wok = wr && ((q.size() < DEPTH) || rok);
`ifdef BYTE_FIFO_ERR_EN
        if (err_clr) begin
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end
        if (wr && !wok)        ovf_m = 1'b1;
        if (rd && q.size() == 0) udf_m = 1'b1;
`endif
        if (rok) begin
            dout_m = q.pop_front();
            popped.push_back(dout_m);
        end
        if (wok) q.push_back(din);
        #1;
        chk_all(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = 8'h00;
`ifdef BYTE_FIFO_ERR_EN
        ovf_m = 1'b0;
        udf_m = 1'b0;
`endif
    endtask

    initial begin
        logic       w;
        logic [7:0] sent[$];
        int         wi;
        logic [7:0] b;

        resetn = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        d_in   = 8'h00;
`ifdef BYTE_FIFO_ERR_EN
        err_clr = 1'b0;
`endif
        model_reset();
        #12;
        @(negedge clk);
        resetn = 1'b1;

        // Reset state held over idle cycles
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 8'h00, w);
        chk("reset.d_out", 32'(d_out), 32'h00);

        // Two writes then two reads
        step("wrA5", 1'b1, 1'b0, 8'hA5, w);
        step("wr3C", 1'b1, 1'b0, 8'h3C, w);
        step("rd1",  1'b0, 1'b1, 8'h00, w);
        chk("rd1.const", 32'(d_out), 32'hA5);
        chk("rd1.cnt",   32'(count), 32'd1);
        step("rd2",  1'b0, 1'b1, 8'h00, w);
        chk("rd2.const", 32'(d_out), 32'h3C);
        chk("rd2.empty", 32'(empty), 32'd1);

        // Overfill: fifth write dropped
        for (int i = 1; i <= 5; i++) begin
            step("fill", 1'b1, 1'b0, 8'(i), w);
            if (i == 4) chk("fill4.full", 32'(full), 32'd1);
        end
        chk("ovf.count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step("drain", 1'b0, 1'b1, 8'h00, w);
            chk("drain.seq", 32'(d_out), 32'(i));
        end

        // Simultaneous read/write while full
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 1'b0, 8'h10 + 8'(i), w);
        step("rwfull", 1'b1, 1'b1, 8'h14, w);
        chk("rwfull.d_out", 32'(d_out), 32'h10);
        chk("rwfull.full",  32'(full),  32'd1);
        for (int i = 1; i <= 4; i++) begin
            step("drain2", 1'b0, 1'b1, 8'h00, w);
            chk("drain2.seq", 32'(d_out), 32'h10 + 32'(i));
        end

        // Random stream of 10 bytes with random read/write interleave
        popped.delete();
        for (int i = 0; i < 10; i++) sent.push_back(8'($urandom));
        wi = 0;
        for (int k = 0; k < 200 && wi < 10; k++) begin
            b = sent[wi];
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, b, w);
            if (w && wr_en === 1'b0) wi++;
        end
        chk("rand.all_written", 32'(wi), 32'd10);
        for (int k = 0; k < DEPTH + 1; k++) step("rdrain", 1'b0, 1'b1, 8'h00, w);
        chk("rand.nout", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk("rand.order", 32'(popped[i]), 32'(sent[i]));

        // Simultaneous read/write on empty: write only
        b = dout_m;
        step("rwempty", 1'b1, 1'b1, 8'h77, w);
        chk("rwempty.cnt",  32'(count), 32'd1);
        chk("rwempty.hold", 32'(d_out), 32'(b));
        step("rd77", 1'b0, 1'b1, 8'h00, w);
        chk("rd77.const", 32'(d_out), 32'h77);

`ifdef BYTE_FIFO_ERR_EN
        // Clear of sticky flags when no set condition is present
        @(negedge clk);
        err_clr = 1'b1;
        step("clr", 1'b0, 1'b0, 8'h00, w);
        err_clr = 1'b0;
`endif

        // Asynchronous reset mid-stream
        step("pre_rst", 1'b1, 1'b0, 8'h5A, w);
        step("pre_rst", 1'b1, 1'b0, 8'h6B, w);
        resetn = 1'b0;
        #2;
        model_reset();
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.full",  32'(full),  32'd0);
        chk("arst.d_out", 32'(d_out), 32'h00);
        @(negedge clk);
        resetn = 1'b1;
        step("post_rst", 1'b0, 1'b1, 8'h00, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
